// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared types and constants for the pipeline stall sequencer.
//   - state_t    : sequencer state encoding (RUN / MEM_WAIT / ERR)
//   - ctrl_t     : bundle of per-stage enable / flush controls
//   - CTRL_*     : canned control patterns for each pipeline situation
//   - run_ctrl() : priority select between branch squash, load-use bubble
//                  and normal flow when no memory stall is in force
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } state_t;

    localparam int REG_ZERO        = 0;
    localparam int DEF_MEM_TIMEOUT = 64;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_REG_W       = 5;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_flush;
    } ctrl_t;

    // Normal flow: everything advances, nothing squashed.
    localparam ctrl_t CTRL_RUN = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                   id_ex_en: 1'b1, id_ex_flush: 1'b0,
                                   ex_mem_en: 1'b1, mem_wb_flush: 1'b0};
    // Data memory busy: freeze PC..EX/MEM, push a bubble into WB.
    localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                      id_ex_en: 1'b0, id_ex_flush: 1'b0,
                                      ex_mem_en: 1'b0, mem_wb_flush: 1'b1};
    // Taken branch: squash the two younger instructions in IF/ID and ID/EX.
    localparam ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                                      id_ex_en: 1'b1, id_ex_flush: 1'b1,
                                      ex_mem_en: 1'b1, mem_wb_flush: 1'b0};
    // Load-use: hold PC and IF/ID one cycle, bubble into EX.
    localparam ctrl_t CTRL_LOAD_USE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                        id_ex_en: 1'b1, id_ex_flush: 1'b1,
                                        ex_mem_en: 1'b1, mem_wb_flush: 1'b0};
    // Reset: nothing advances, every bubble point loads a bubble.
    localparam ctrl_t CTRL_RESET = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
                                     id_ex_en: 1'b0, id_ex_flush: 1'b1,
                                     ex_mem_en: 1'b0, mem_wb_flush: 1'b1};
    // Fault: same freeze shape as a memory stall, held until reset.
    localparam ctrl_t CTRL_ERR = CTRL_FREEZE;

    // Branch outranks load-use: the instruction that would consume the
    // load result is being squashed anyway.
    function automatic ctrl_t run_ctrl(input logic branch, input logic hazard);
        if (branch)
            return CTRL_BRANCH;
        else if (hazard)
            return CTRL_LOAD_USE;
        else
            return CTRL_RUN;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
//   Combinational load-use hazard compare between the instruction in ID and
//   a load sitting in EX. Register 0 is hard-wired so it never hazards.
//   Ports:
//     id_rs, id_rt    : source specifiers of the instruction in ID
//     id_ex_mem_read  : instruction in EX is a load
//     id_ex_rd        : destination specifier of the instruction in EX
//     hazard          : 1 when ID needs a value the EX load has not produced
// ---------------------------------------------------------------------------
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rd,
    output logic             hazard
);

    logic rd_live;
    logic rd_match;

    assign rd_live  = (id_ex_rd != REG_W'(REG_ZERO));
    assign rd_match = (id_ex_rd == id_rs) || (id_ex_rd == id_rt);
    assign hazard   = id_ex_mem_read && rd_live && rd_match;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
//   Hazard and stall sequencer for the 5-stage pipeline. Produces per-stage
//   enable / bubble controls from load-use hazards, taken branches and data
//   memory wait states. Memory waits are tracked by a small FSM with a
//   watchdog; a saturating counter records cycles in which the PC is held.
//   Controls are Mealy (state + current inputs, zero latency).
//   Ports:
//     clk, rst               : clock, asynchronous active-low reset
//     id_rs, id_rt           : sources of the instruction in ID
//     id_ex_mem_read,id_ex_rd: load flag / destination of instruction in EX
//     branch_taken           : EX resolved a taken branch/jump
//     mem_req, mem_ready     : MEM access issued / completing this cycle
//     pc_en .. mem_wb_flush  : per-stage enable and bubble controls
//     mem_err                : sticky memory-timeout fault (cleared by reset)
//     stall_cycles           : saturating count of cycles with pc_en=0
//   MEM_TIMEOUT must be at least 2.
// ---------------------------------------------------------------------------
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int REG_W       = DEF_REG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    // wait_cnt reaches MEM_TIMEOUT on the cycle the FSM enters ERR.
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              hazard;
    logic              miss;
    ctrl_t             ctrl;

    load_use_detect #(.REG_W(REG_W)) u_load_use (
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rd       (id_ex_rd),
        .hazard         (hazard)
    );

    // A ready without a request is meaningless and falls through to normal
    // flow; a request with ready is a single-cycle hit.
    assign miss = mem_req && !mem_ready;

    always_comb begin
        ctrl      = CTRL_RUN;
        state_nxt = state;
        wait_nxt  = wait_cnt;
        unique case (state)
            RUN: begin
                if (miss) begin
                    ctrl      = CTRL_FREEZE;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end else begin
                    ctrl = run_ctrl(branch_taken, hazard);
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    ctrl     = CTRL_FREEZE;
                    wait_nxt = wait_cnt + WAIT_W'(1);
                    if (wait_cnt == WAIT_LAST)
                        state_nxt = ERR;
                end else begin
                    // Release cycle: mem_req is deliberately not looked at;
                    // a following miss is caught next cycle from RUN. The
                    // frozen EX stage may still hold a taken branch.
                    ctrl      = run_ctrl(branch_taken, hazard);
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end
            end
            ERR: begin
                ctrl = CTRL_ERR;
            end
            default: begin
                // Unused encoding: hold the pipe and fall back to RUN.
                ctrl      = CTRL_FREEZE;
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase
        // Reset overrides everything combinationally, not just at the edge.
        if (!rst)
            ctrl = CTRL_RESET;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cycles <= '0;
        else if (!ctrl.pc_en && (stall_cycles != CNT_MAX))
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_en     = ctrl.id_ex_en;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign mem_err      = (state == ERR);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl
//   Directed vector table, a hand-written asynchronous-reset sequence and a
//   randomized run checked against a cycle-level behavioural model.
//   Control vector order: {pc_en, if_id_en, if_id_flush, id_ex_en,
//                          id_ex_flush, ex_mem_en, mem_wb_flush}
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

    localparam int TO    = 4;
    localparam int CW    = 4;
    localparam int RW    = 5;
    localparam int SMAX  = (1 << CW) - 1;

    localparam logic [6:0] V_RUN = 7'b1101010;
    localparam logic [6:0] V_FRZ = 7'b0000001;
    localparam logic [6:0] V_BR  = 7'b1111110;
    localparam logic [6:0] V_LU  = 7'b0001110;
    localparam logic [6:0] V_RST = 7'b0010101;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_rs, id_rt, id_ex_rd;
    logic          id_ex_mem_read, branch_taken, mem_req, mem_ready;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic          ex_mem_en, mem_wb_flush, mem_err;
    logic [CW-1:0] stall_cycles;

    pipe_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW), .REG_W(RW)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rd       (id_ex_rd),
        .branch_taken   (branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .if_id_flush    (if_id_flush),
        .id_ex_en       (id_ex_en),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_en      (ex_mem_en),
        .mem_wb_flush   (mem_wb_flush),
        .mem_err        (mem_err),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [RW-1:0] rs, rt, rd;
        logic          mr, br, req, rdy;
        logic [6:0]    ctrl;
        int            stall;
        logic          err;
    } vec_t;

    vec_t tbl[34];
    int   n_cmp = 0;
    int   n_bad = 0;

    // behavioural model state
    bit   m_busy, m_dead;
    int   m_frozen, m_stalls;

    function automatic vec_t mk(logic r, int rs, int rt, int rd, logic mr,
                                logic br, logic req, logic rdy,
                                logic [6:0] c, int s, logic e);
        vec_t v;
        v.rst = r; v.rs = RW'(rs); v.rt = RW'(rt); v.rd = RW'(rd);
        v.mr = mr; v.br = br; v.req = req; v.rdy = rdy;
        v.ctrl = c; v.stall = s; v.err = e;
        return v;
    endfunction

    function automatic logic [6:0] ctrl_now();
        return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                ex_mem_en, mem_wb_flush};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; id_rs = v.rs; id_rt = v.rt; id_ex_rd = v.rd;
        id_ex_mem_read = v.mr; branch_taken = v.br;
        mem_req = v.req; mem_ready = v.rdy;
    endtask

    task automatic check_all(input string tag, input logic [6:0] c, input int s, input logic e);
        chk({tag, ".ctrl"}, int'(ctrl_now()), int'(c));
        chk({tag, ".stall_cycles"}, int'(stall_cycles), s);
        chk({tag, ".mem_err"}, int'(mem_err), int'(e));
    endtask

    // Behavioural model: returns expected outputs for this cycle, then
    // advances to the state seen after the coming clock edge.
    task automatic model_step(input vec_t v, output logic [6:0] c,
                              output int s, output logic e);
        bit hz, frz;
        if (!v.rst) begin
            m_busy = 0; m_dead = 0; m_frozen = 0; m_stalls = 0;
            c = V_RST; s = 0; e = 0;
            return;
        end
        s  = m_stalls;
        e  = m_dead;
        hz = v.mr && (v.rd != 0) && (v.rd == v.rs || v.rd == v.rt);
        frz = m_busy ? !v.rdy : (v.req && !v.rdy);
        if (m_dead) begin
            c = V_FRZ;
        end else if (frz) begin
            c = V_FRZ;
            m_busy = 1;
            m_frozen++;
            if (m_frozen == TO) m_dead = 1;
        end else begin
            m_busy = 0;
            m_frozen = 0;
            c = v.br ? V_BR : (hz ? V_LU : V_RUN);
        end
        if (!c[6]) m_stalls = (m_stalls < SMAX) ? m_stalls + 1 : SMAX;
    endtask

    initial begin
        vec_t v;
        logic [6:0] ec;
        int es;
        logic ee;

        //            rst rs rt rd mr br rq rdy ctrl   stall err
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, V_RST, 0,  0); // in reset
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, V_RUN, 0,  0); // idle
        tbl[2]  = mk(1, 5, 0, 5, 1, 0, 0, 0, V_LU,  0,  0); // load-use rs
        tbl[3]  = mk(1, 1, 2, 3, 0, 0, 0, 0, V_RUN, 1,  0);
        tbl[4]  = mk(1, 0, 0, 0, 1, 0, 0, 0, V_RUN, 1,  0); // rd=0 no hazard
        tbl[5]  = mk(1, 3, 7, 7, 1, 0, 0, 0, V_LU,  1,  0); // load-use rt
        tbl[6]  = mk(1, 0, 0, 0, 0, 0, 0, 0, V_RUN, 2,  0);
        tbl[7]  = mk(1, 5, 0, 5, 1, 1, 0, 0, V_BR,  2,  0); // branch beats LU
        tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0, 0, V_RUN, 2,  0);
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 1, 1, V_RUN, 2,  0); // single-cycle hit
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 0, 1, V_RUN, 2,  0); // ready w/o req
        tbl[11] = mk(1, 0, 0, 0, 0, 0, 1, 0, V_FRZ, 2,  0); // 3-cycle wait
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 1, 0, V_FRZ, 3,  0);
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 1, 0, V_FRZ, 4,  0);
        tbl[14] = mk(1, 0, 0, 0, 0, 0, 1, 1, V_RUN, 5,  0); // release
        tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 0, V_RUN, 5,  0);
        tbl[16] = mk(1, 0, 0, 0, 0, 1, 1, 0, V_FRZ, 5,  0); // deferred branch
        tbl[17] = mk(1, 0, 0, 0, 0, 1, 1, 0, V_FRZ, 6,  0);
        tbl[18] = mk(1, 0, 0, 0, 0, 1, 1, 1, V_BR,  7,  0);
        tbl[19] = mk(1, 0, 0, 0, 0, 0, 0, 0, V_RUN, 7,  0);
        tbl[20] = mk(1, 0, 0, 0, 0, 0, 1, 0, V_FRZ, 7,  0); // LU on release
        tbl[21] = mk(1, 6, 0, 6, 1, 0, 1, 1, V_LU,  8,  0);
        tbl[22] = mk(1, 0, 0, 0, 0, 0, 0, 0, V_RUN, 9,  0);
        tbl[23] = mk(1, 0, 0, 0, 0, 0, 1, 0, V_FRZ, 9,  0); // back-to-back
        tbl[24] = mk(1, 0, 0, 0, 0, 0, 1, 1, V_RUN, 10, 0);
        tbl[25] = mk(1, 0, 0, 0, 0, 0, 1, 0, V_FRZ, 10, 0);
        tbl[26] = mk(1, 0, 0, 0, 0, 0, 1, 1, V_RUN, 11, 0);
        tbl[27] = mk(1, 0, 0, 0, 0, 0, 1, 0, V_FRZ, 11, 0); // timeout
        tbl[28] = mk(1, 0, 0, 0, 0, 0, 1, 0, V_FRZ, 12, 0);
        tbl[29] = mk(1, 0, 0, 0, 0, 0, 1, 0, V_FRZ, 13, 0);
        tbl[30] = mk(1, 0, 0, 0, 0, 0, 1, 0, V_FRZ, 14, 0);
        tbl[31] = mk(1, 0, 0, 0, 0, 0, 0, 1, V_FRZ, 15, 1); // ERR, sticky
        tbl[32] = mk(1, 0, 0, 0, 0, 1, 1, 1, V_FRZ, 15, 1); // saturated
        tbl[33] = mk(1, 0, 0, 0, 0, 0, 0, 0, V_FRZ, 15, 1);

        drive(tbl[0]);
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check_all($sformatf("vec%0d", i), tbl[i].ctrl, tbl[i].stall, tbl[i].err);
        end

        // Asynchronous reset in the middle of a cycle while in ERR.
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", V_RST, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all("post_rst0", V_RUN, 0, 1'b0);
        @(negedge clk);
        #1;
        check_all("post_rst1", V_RUN, 0, 1'b0);

        // Randomized run against the behavioural model.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            v.rst = (i == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
            v.rs  = RW'($urandom_range(0, 3));
            v.rt  = RW'($urandom_range(0, 3));
            v.rd  = RW'($urandom_range(0, 3));
            v.mr  = $urandom_range(0, 1) != 0;
            v.br  = $urandom_range(0, 4) == 0;
            v.req = $urandom_range(0, 2) == 0;
            v.rdy = $urandom_range(0, 2) != 0;
            drive(v);
            #1;
            model_step(v, ec, es, ee);
            check_all($sformatf("rnd%0d", i), ec, es, ee);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
